// File: rtl/gear_shift_pkg.sv
// Shared definitions for the gear shift register block.
//   mode_t      : operation select encoding (HOLD, SHL, SHR, LOAD)
//   fill_width  : bit width needed to count 0..size valid bits
package gear_shift_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'd0,
        MODE_SHL  = 2'd1,
        MODE_SHR  = 2'd2,
        MODE_LOAD = 2'd3
    } mode_t;

    function automatic int fill_width(input int size);
        return $clog2(size + 1);
    endfunction

endpackage

// File: rtl/gear_shift_register_if.sv
// Bus bundle for gear_shift_register.
//   master : drives en, mode, in, load_data; observes q, out, out_lsb, fill, full
//   slave  : the register itself (opposite directions)
interface gear_shift_register_if #(
    parameter int SIZE  = 64,
    parameter int IN_W  = 5,
    parameter int OUT_W = 4
);
    import gear_shift_pkg::*;

    localparam int FILL_W = fill_width(SIZE);

    logic              en;
    mode_t             mode;
    logic [IN_W-1:0]   in;
    logic [SIZE-1:0]   load_data;
    logic [SIZE-1:0]   q;
    logic [OUT_W-1:0]  out;
    logic [OUT_W-1:0]  out_lsb;
    logic [FILL_W-1:0] fill;
    logic              full;

    modport master (
        output en, mode, in, load_data,
        input  q, out, out_lsb, fill, full
    );

    modport slave (
        input  en, mode, in, load_data,
        output q, out, out_lsb, fill, full
    );

endinterface

// File: rtl/sat_fill_counter.sv
// Saturating up-counter tracking how many valid bits the register holds.
//   clk     : clock, rising edge
//   reset   : synchronous, active-high; clears count
//   inc     : add STEP, clamped at MAX
//   set_max : jump straight to MAX (parallel load)
//   count   : current value, 0..MAX
module sat_fill_counter #(
    parameter int MAX  = 64,
    parameter int STEP = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       inc,
    input  logic                       set_max,
    output logic [$clog2(MAX+1)-1:0]   count
);

    localparam int W = $clog2(MAX + 1);
    localparam logic [W:0] MAX_EXT  = (W+1)'(MAX);
    localparam logic [W:0] STEP_EXT = (W+1)'(STEP);

    // One extra bit of headroom so count + STEP can never wrap before the clamp.
    logic [W:0] sum;
    assign sum = {1'b0, count} + STEP_EXT;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (set_max) begin
            count <= MAX_EXT[W-1:0];
        end else if (inc) begin
            count <= (sum > MAX_EXT) ? MAX_EXT[W-1:0] : sum[W-1:0];
        end
    end

endmodule

// File: rtl/gear_shift_register.sv
// Gear shift register: SIZE-bit register that accepts IN_W-bit chunks shifted
// in from either end, or a parallel load, and exposes OUT_W-bit taps at both
// ends plus a saturating count of how many bits are valid.
//   clk, reset : clock and synchronous active-high reset
//   bus.en     : cycle enable; 0 freezes q and fill
//   bus.mode   : HOLD / SHL / SHR / LOAD
//   bus.in     : chunk inserted on SHL (at LSB end) or SHR (at MSB end)
//   bus.load_data : parallel value for LOAD
//   bus.q      : full register contents
//   bus.out    : top OUT_W bits of q;  bus.out_lsb : bottom OUT_W bits of q
//   bus.fill   : valid-bit count, saturates at SIZE;  bus.full : fill == SIZE
module gear_shift_register #(
    parameter int SIZE  = 64,
    parameter int IN_W  = 5,
    parameter int OUT_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    gear_shift_register_if.slave  bus
);
    import gear_shift_pkg::*;

    localparam int FILL_W = fill_width(SIZE);

    if (IN_W < 1 || IN_W >= SIZE || OUT_W < 1 || OUT_W > SIZE) begin : g_bad_params
        $fatal(1, "gear_shift_register: illegal parameters SIZE=%0d IN_W=%0d OUT_W=%0d",
               SIZE, IN_W, OUT_W);
    end

    logic [SIZE-1:0]   q;
    logic [FILL_W-1:0] fill;
    logic              do_shift;
    logic              do_load;

    assign do_shift = bus.en && (bus.mode == MODE_SHL || bus.mode == MODE_SHR);
    assign do_load  = bus.en && (bus.mode == MODE_LOAD);

    // Every branch writes the whole of q, so no slice is ever left undefined.
    // NOTE: reset is synchronous and checked first, so it beats en and mode.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (bus.en) begin
            unique case (bus.mode)
                MODE_SHL:  q <= {q[SIZE-1-IN_W:0], bus.in};
                MODE_SHR:  q <= {bus.in, q[SIZE-1:IN_W]};
                MODE_LOAD: q <= bus.load_data;
                default:   q <= q;
            endcase
        end
    end

    sat_fill_counter #(
        .MAX  (SIZE),
        .STEP (IN_W)
    ) u_fill (
        .clk     (clk),
        .reset   (reset),
        .inc     (do_shift),
        .set_max (do_load),
        .count   (fill)
    );

    assign bus.q       = q;
    assign bus.out     = q[SIZE-1 -: OUT_W];
    assign bus.out_lsb = q[OUT_W-1:0];
    assign bus.fill    = fill;
    assign bus.full    = (fill == FILL_W'(SIZE));

endmodule

// File: tb/tb_gear_shift_register.sv
// Self-checking bench for gear_shift_register (SIZE=64, IN_W=5, OUT_W=4):
// a constant vector table, hand-written multi-cycle sequences, then random
// traffic compared against an arithmetic reference model.
module tb_gear_shift_register;
    import gear_shift_pkg::*;

    localparam int SIZE  = 64;
    localparam int IN_W  = 5;
    localparam int OUT_W = 4;

    logic clk;
    logic reset;

    gear_shift_register_if #(.SIZE(SIZE), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    gear_shift_register #(.SIZE(SIZE), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: q as a 64-bit number, fill as a plain integer.
    logic [63:0] m_q;
    int          m_fill;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs, clock it, advance the model, settle 1ns.
    task automatic drive(input logic rst, input logic en, input mode_t mode,
                         input logic [IN_W-1:0] din, input logic [SIZE-1:0] ld);
        reset         = rst;
        bus.en        = en;
        bus.mode      = mode;
        bus.in        = din;
        bus.load_data = ld;
        @(posedge clk);
        if (rst) begin
            m_q    = '0;
            m_fill = 0;
        end else if (en) begin
            case (mode)
                MODE_SHL: begin
                    m_q    = (m_q << IN_W) | 64'(din);
                    m_fill = (m_fill + IN_W > SIZE) ? SIZE : m_fill + IN_W;
                end
                MODE_SHR: begin
                    m_q    = (m_q >> IN_W) | (64'(din) << (SIZE - IN_W));
                    m_fill = (m_fill + IN_W > SIZE) ? SIZE : m_fill + IN_W;
                end
                MODE_LOAD: begin
                    m_q    = ld;
                    m_fill = SIZE;
                end
                default: ;
            endcase
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, " q"},       bus.q,              m_q);
        check({tag, " fill"},    64'(bus.fill),      64'(m_fill));
        check({tag, " out"},     64'(bus.out),       64'(m_q[63:60]));
        check({tag, " out_lsb"}, 64'(bus.out_lsb),   64'(m_q[3:0]));
        check({tag, " full"},    64'(bus.full),      64'(m_fill == SIZE));
    endtask

    typedef struct {
        logic            rst;
        logic            en;
        mode_t           mode;
        logic [4:0]      din;
        logic [63:0]     ld;
        logic [63:0]     exp_q;
        int              exp_fill;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{1'b1, 1'b1, MODE_LOAD, 5'h00, 64'h1234,                 64'h0,                  0};
        tbl[1] = '{1'b0, 1'b1, MODE_SHL,  5'h16, 64'h0,                    64'h16,                 5};
        tbl[2] = '{1'b0, 1'b1, MODE_SHL,  5'h01, 64'h0,                    64'h2C1,                10};
        tbl[3] = '{1'b0, 1'b1, MODE_SHR,  5'h1F, 64'h0,                    64'hF800_0000_0000_0016, 15};
        tbl[4] = '{1'b0, 1'b0, MODE_SHL,  5'h1F, 64'h0,                    64'hF800_0000_0000_0016, 15};
        tbl[5] = '{1'b0, 1'b1, MODE_HOLD, 5'h1F, 64'hFFFF,                 64'hF800_0000_0000_0016, 15};
        tbl[6] = '{1'b0, 1'b1, MODE_LOAD, 5'h00, 64'hDEAD_BEEF_0123_4567,  64'hDEAD_BEEF_0123_4567, 64};
        tbl[7] = '{1'b1, 1'b1, MODE_SHL,  5'h1F, 64'h0,                    64'h0,                  0};
        tbl[8] = '{1'b1, 1'b1, MODE_LOAD, 5'h00, 64'hFFFF_FFFF_FFFF_FFFF,  64'h0,                  0};
        tbl[9] = '{1'b0, 1'b1, MODE_SHR,  5'h1F, 64'h0,                    64'hF800_0000_0000_0000, 5};

        m_q    = '0;
        m_fill = 0;
        reset  = 1'b1;
        bus.en = 1'b0;
        bus.mode = MODE_HOLD;
        bus.in = '0;
        bus.load_data = '0;
        repeat (2) @(posedge clk);
        #1;

        // ---- table-driven vectors ----
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].rst, tbl[i].en, tbl[i].mode, tbl[i].din, tbl[i].ld);
            check($sformatf("tbl%0d q", i),       bus.q,            tbl[i].exp_q);
            check($sformatf("tbl%0d fill", i),    64'(bus.fill),    64'(tbl[i].exp_fill));
            check($sformatf("tbl%0d out", i),     64'(bus.out),     64'(tbl[i].exp_q[63:60]));
            check($sformatf("tbl%0d out_lsb", i), 64'(bus.out_lsb), 64'(tbl[i].exp_q[3:0]));
            check($sformatf("tbl%0d full", i),    64'(bus.full),    64'(tbl[i].exp_fill == 64));
        end

        // ---- random LOAD then reset ----
        drive(1'b0, 1'b1, MODE_LOAD, 5'h0, {$urandom, $urandom});
        drive(1'b1, 1'b0, MODE_HOLD, 5'h0, 64'h0);
        check("rst_after_load q",       bus.q,            64'h0);
        check("rst_after_load out",     64'(bus.out),     64'h0);
        check("rst_after_load out_lsb", 64'(bus.out_lsb), 64'h0);
        check("rst_after_load fill",    64'(bus.fill),    64'h0);
        check("rst_after_load full",    64'(bus.full),    64'h0);

        // ---- SHL fill to saturation ----
        drive(1'b0, 1'b1, MODE_SHL, 5'b10110, 64'h0);
        check("shl1 q",       bus.q,            64'h16);
        check("shl1 out_lsb", 64'(bus.out_lsb), 64'h6);
        check("shl1 fill",    64'(bus.fill),    64'd5);
        for (int i = 0; i < 11; i++) drive(1'b0, 1'b1, MODE_SHL, 5'h0, 64'h0);
        check("shl12 fill", 64'(bus.fill), 64'd60);
        check("shl12 full", 64'(bus.full), 64'h0);
        drive(1'b0, 1'b1, MODE_SHL, 5'h0, 64'h0);
        check("shl13 fill", 64'(bus.fill), 64'd64);
        check("shl13 full", 64'(bus.full), 64'h1);
        check("shl13 q",    bus.q,         64'h6000_0000_0000_0000);
        drive(1'b0, 1'b1, MODE_SHR, 5'h0, 64'h0);
        check("sat_hold fill", 64'(bus.fill), 64'd64);

        // ---- LOAD then 3 HOLD cycles ----
        drive(1'b0, 1'b1, MODE_LOAD, 5'h0, 64'hDEAD_BEEF_0123_4567);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, MODE_HOLD, 5'h1F, 64'h0);
            check($sformatf("hold%0d q", i),       bus.q,            64'hDEAD_BEEF_0123_4567);
            check($sformatf("hold%0d out", i),     64'(bus.out),     64'hD);
            check($sformatf("hold%0d out_lsb", i), 64'(bus.out_lsb), 64'h7);
            check($sformatf("hold%0d fill", i),    64'(bus.fill),    64'd64);
            check($sformatf("hold%0d full", i),    64'(bus.full),    64'h1);
        end

        // ---- en=0 freeze for 4 cycles, then reset with LOAD ----
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, MODE_SHL, 5'h1F, 64'h0);
            check($sformatf("freeze%0d q", i),    bus.q,         64'hDEAD_BEEF_0123_4567);
            check($sformatf("freeze%0d fill", i), 64'(bus.fill), 64'd64);
        end
        drive(1'b1, 1'b1, MODE_LOAD, 5'h0, 64'hFFFF_0000_FFFF_0000);
        check("rst_vs_load q",    bus.q,         64'h0);
        check("rst_vs_load fill", 64'(bus.fill), 64'h0);

        // ---- reset mid-fill ----
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, MODE_SHL, 5'(i + 3), 64'h0);
        check("midfill fill", 64'(bus.fill), 64'd30);
        drive(1'b1, 1'b1, MODE_SHL, 5'h1F, 64'h0);
        check("midfill_rst q",    bus.q,         64'h0);
        check("midfill_rst fill", 64'(bus.fill), 64'h0);
        drive(1'b0, 1'b1, MODE_SHL, 5'h0A, 64'h0);
        check("post_rst_shl fill", 64'(bus.fill), 64'd5);
        check("post_rst_shl q",    bus.q,         64'hA);

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 24) == 0),
                  ($urandom_range(0, 5) != 0),
                  mode_t'($urandom_range(0, 3)),
                  5'($urandom),
                  ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'h0);
            check_model($sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gear_shift_register.md
GEAR_SHIFT_REGISTER -- requirements
Module: gear_shift_register

Interface
REQ-001 SHALL have parameter SIZE, default 64, register length in bits.
REQ-002 SHALL have parameter IN_W, default 5, bits inserted per shift.
REQ-003 SHALL have parameter OUT_W, default 4, width of each output tap.
REQ-004 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port en  input  1  cycle enable; 0 freezes all state.
REQ-007 SHALL have port mode  input  2  operation: 0 HOLD, 1 SHL, 2 SHR, 3 LOAD.
REQ-008 SHALL have port in  input  IN_W  serial chunk inserted on SHL/SHR.
REQ-009 SHALL have port load_data  input  SIZE  parallel value for LOAD.
REQ-010 SHALL have port q  output  SIZE  full register contents.
REQ-011 SHALL have port out  output  OUT_W  q[SIZE-1:SIZE-OUT_W], MSB tap.
REQ-012 SHALL have port out_lsb  output  OUT_W  q[OUT_W-1:0], LSB tap.
REQ-013 SHALL have port fill  output  clog2(SIZE+1)  count of valid bits, saturating at SIZE.
REQ-014 SHALL have port full  output  1  high when fill == SIZE.

Function
REQ-015 SHL (en=1): q <= {q[SIZE-1-IN_W:0], in}; in[IN_W-1] lands deepest, matching bit-serial MSB-first insertion.
REQ-016 SHR (en=1): q <= {in, q[SIZE-1:IN_W]}; in occupies q[SIZE-1:SIZE-IN_W] unreversed.
REQ-017 LOAD (en=1): q <= load_data; fill <= SIZE.
REQ-018 HOLD, or en=0 in any mode: q and fill unchanged.
REQ-019 SHL/SHR: fill <= min(fill + IN_W, SIZE); no wrap-around, no overflow of the fill width.
REQ-020 out, out_lsb, full: purely combinational from q/fill; q and fill change one cycle after the qualifying edge (latency 1).
REQ-021 Bits shifted out of either end are discarded; no carry or overflow output.
REQ-022 Legal parameters: 1 <= IN_W < SIZE, 1 <= OUT_W <= SIZE; violation SHALL stop elaboration.
REQ-023 Every bit of q is written in every update; no X from unused slices.

Reset
REQ-024 reset=1 at a rising edge SHALL force q=0, fill=0, independent of en and mode.
REQ-025 Reset values: q=0, out=0, out_lsb=0, fill=0, full=0.
REQ-026 reset with LOAD, SHL or SHR in the same cycle: reset wins.
REQ-027 Reset mid-fill discards contents; first post-reset SHL yields fill=IN_W.

Structure
REQ-028 A shared package gear_shift_pkg SHALL hold the mode encodings (MODE_HOLD=0, MODE_SHL=1, MODE_SHR=2, MODE_LOAD=3).
REQ-029 The saturating fill counter SHALL be the sub-module sat_fill_counter (parameters MAX, STEP; inputs clk, reset, inc, set_max).
REQ-030 Data path (q) SHALL be a single always block in gear_shift_register; no other hierarchy.

Verification (SIZE=64, IN_W=5, OUT_W=4)
REQ-031 reset=1 for 1 cycle after random LOAD -> q=0, out=0, out_lsb=0, fill=0, full=0.
REQ-032 After reset, SHL in=5'b10110 -> q=64'h16, out_lsb=4'h6, fill=5; 12 more SHL -> fill=64 (saturated, not 65), full=1.
REQ-033 After reset, SHR in=5'b11111 -> q[63:59]=5'b11111, out=4'hF, out_lsb=4'h0, fill=5.
REQ-034 LOAD load_data=64'hDEAD_BEEF_0123_4567 -> q matches, out=4'hD, out_lsb=4'h7, fill=64, full=1; then 3 HOLD cycles -> unchanged.
REQ-035 en=0 with mode=SHL, in=5'h1F for 4 cycles -> q and fill unchanged; reset=1 with mode=LOAD -> q=0, fill=0.
REQ-036 Six SHL cycles (fill=30), then reset -> fill=0, q=0 next cycle; next SHL -> fill=5.
